// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-stage next-PC sequencer.
package pc_seq_pkg;

  localparam int PC_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    HOLD,
    SEQ,
    REL,
    ABS,
    CALL,
    RET,
    START
  } pc_src_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control, LUT and status signals between the fetch control and the sequencer.
interface pc_sequencer_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 2
);
    logic              Start;
    logic [PC_W-1:0]   StartAddr;
    logic              Stall;
    logic              Halt;
    logic              BranchRel;
    logic              BranchAbs;
    logic              Call;
    logic              Ret;
    logic [LUT_AW-1:0] LutSel;
    logic [LUT_AW-1:0] LutAddr;
    logic [PC_W-1:0]   LutTarget;
    logic [PC_W-1:0]   PC;
    logic              Running;
    logic              Done;
    logic              RasOverflow;
    logic              RasUnderflow;

    modport master (
        output Start, StartAddr, Stall, Halt, BranchRel, BranchAbs, Call, Ret,
               LutSel, LutTarget,
        input  LutAddr, PC, Running, Done, RasOverflow, RasUnderflow
    );

    modport slave (
        input  Start, StartAddr, Stall, Halt, BranchRel, BranchAbs, Call, Ret,
               LutSel, LutTarget,
        output LutAddr, PC, Running, Done, RasOverflow, RasUnderflow
    );
endinterface

// File: rtl/pc_ras.sv
// Return-address LIFO; push and pop are never requested together.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] cnt;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign dout  = mem[AW'(cnt - CW'(1))];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (push && !full) begin
            mem[AW'(cnt)] <= din;
            cnt           <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC controller: priority encoder, PC/FSM register, return stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              LUT_AW    = 2,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input logic           Clk,
    input logic           Reset,
    pc_sequencer_if.slave bus
);
    state_t          state;
    pc_src_t         src;
    logic [PC_W-1:0] pc_q, pc_nxt, pc_inc, ras_top;
    logic            running_q, done_q, ovf_q, unf_q;
    logic            ras_full, ras_empty, ras_push, ras_pop, unf_set;

    assign bus.LutAddr      = LUT_AW'(bus.LutSel);
    assign bus.PC           = pc_q;
    assign bus.Running      = running_q;
    assign bus.Done         = done_q;
    assign bus.RasOverflow  = ovf_q;
    assign bus.RasUnderflow = unf_q;

    assign pc_inc = pc_q + PC_W'(1);

    // An empty-stack Ret degrades to a sequential step and raises underflow.
    always_comb begin
        src     = HOLD;
        unf_set = 1'b0;
        unique case (state)
            IDLE: if (bus.Start) src = START;
            RUN: begin
                if (bus.Stall || bus.Halt) src = HOLD;
                else if (bus.Ret) begin
                    if (!ras_empty) src = RET;
                    else begin
                        src     = SEQ;
                        unf_set = 1'b1;
                    end
                end
                else if (bus.Call)      src = CALL;
                else if (bus.BranchAbs) src = ABS;
                else if (bus.BranchRel) src = REL;
                else                    src = SEQ;
            end
            default: src = HOLD;
        endcase
    end

    always_comb begin
        pc_nxt = pc_q;
        unique case (src)
            SEQ:        pc_nxt = pc_inc;
            REL:        pc_nxt = pc_q + bus.LutTarget;
            ABS, CALL:  pc_nxt = bus.LutTarget;
            RET:        pc_nxt = ras_top;
            START:      pc_nxt = bus.StartAddr;
            default:    pc_nxt = pc_q;
        endcase
    end

    assign ras_push = (src == CALL) && !ras_full;
    assign ras_pop  = (src == RET);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            pc_q <= pc_nxt;
            if (unf_set)                   unf_q <= 1'b1;
            if (src == CALL && ras_full)   ovf_q <= 1'b1;
            unique case (state)
                IDLE: if (bus.Start) begin
                    state     <= RUN;
                    running_q <= 1'b1;
                end
                RUN: if (!bus.Stall && bus.Halt) begin
                    state     <= DONE;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk   (Clk),
        .rst   (Reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_inc),
        .dout  (ras_top),
        .full  (ras_full),
        .empty (ras_empty)
    );
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
    localparam int PC_W   = 10;
    localparam int LUT_AW = 2;

    // control bit positions: {start, stall, halt, ret, call, babs, brel}
    localparam logic [6:0] S  = 7'b1000000;
    localparam logic [6:0] ST = 7'b0100000;
    localparam logic [6:0] H  = 7'b0010000;
    localparam logic [6:0] R  = 7'b0001000;
    localparam logic [6:0] C  = 7'b0000100;
    localparam logic [6:0] A  = 7'b0000010;
    localparam logic [6:0] B  = 7'b0000001;
    localparam logic [6:0] N  = 7'b0000000;

    typedef struct {
        logic [6:0]        ctrl;
        logic [PC_W-1:0]   sa;
        logic [LUT_AW-1:0] sel;
        logic [PC_W-1:0]   tgt;
        logic [PC_W-1:0]   exp_pc;
        logic [3:0]        exp_fl;   // {running, done, overflow, underflow}
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus ();

    pc_sequencer #(
        .PC_W      (PC_W),
        .LUT_AW    (LUT_AW),
        .RAS_DEPTH (4),
        .RESET_PC  (10'h000)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    function automatic vec_t mk(logic [6:0] c, logic [PC_W-1:0] sa, logic [LUT_AW-1:0] sel,
                                logic [PC_W-1:0] tgt, logic [PC_W-1:0] pc, logic [3:0] fl);
        vec_t v;
        v.ctrl = c; v.sa = sa; v.sel = sel; v.tgt = tgt; v.exp_pc = pc; v.exp_fl = fl;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic [6:0] c, input logic [PC_W-1:0] sa,
                         input logic [LUT_AW-1:0] sel, input logic [PC_W-1:0] tgt);
        {bus.Start, bus.Stall, bus.Halt, bus.Ret, bus.Call, bus.BranchAbs, bus.BranchRel} = c;
        bus.StartAddr = sa;
        bus.LutSel    = sel;
        bus.LutTarget = tgt;
    endtask

    task automatic check_out(input string tag, input logic [PC_W-1:0] pc, input logic [3:0] fl);
        chk({tag, ".pc"},   int'(bus.PC),           int'(pc));
        chk({tag, ".run"},  int'(bus.Running),      int'(fl[3]));
        chk({tag, ".done"}, int'(bus.Done),         int'(fl[2]));
        chk({tag, ".ovf"},  int'(bus.RasOverflow),  int'(fl[1]));
        chk({tag, ".unf"},  int'(bus.RasUnderflow), int'(fl[0]));
    endtask

    task automatic step(input string tag, input vec_t v);
        drive(v.ctrl, v.sa, v.sel, v.tgt);
        #1;
        chk({tag, ".lutaddr"}, int'(bus.LutAddr), int'(v.sel));
        @(posedge clk); #1;
        check_out(tag, v.exp_pc, v.exp_fl);
    endtask

    vec_t vt[$];

    initial begin
        rst = 1'b1;
        drive(N, '0, '0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_out("reset", 10'h000, 4'b0000);
        rst = 1'b0;

        vt.push_back(mk(S, 10'h010, 0, 10'h000, 10'h010, 4'b1000));
        vt.push_back(mk(N, 10'h000, 1, 10'h000, 10'h011, 4'b1000));
        vt.push_back(mk(N, 10'h000, 2, 10'h000, 10'h012, 4'b1000));
        vt.push_back(mk(N, 10'h000, 3, 10'h000, 10'h013, 4'b1000));
        vt.push_back(mk(A, 10'h000, 1, 10'h020, 10'h020, 4'b1000));
        vt.push_back(mk(B, 10'h000, 0, 10'h3F0, 10'h010, 4'b1000)); // -16
        vt.push_back(mk(A, 10'h000, 2, 10'h3FF, 10'h3FF, 4'b1000));
        vt.push_back(mk(N, 10'h000, 0, 10'h000, 10'h000, 4'b1000)); // wrap
        vt.push_back(mk(A, 10'h000, 0, 10'h050, 10'h050, 4'b1000));
        vt.push_back(mk(C, 10'h000, 1, 10'h007, 10'h007, 4'b1000)); // push 051
        vt.push_back(mk(N, 10'h000, 0, 10'h000, 10'h008, 4'b1000));
        vt.push_back(mk(R, 10'h000, 0, 10'h000, 10'h051, 4'b1000));
        vt.push_back(mk(B, 10'h000, 2, 10'h005, 10'h056, 4'b1000));
        vt.push_back(mk(S, 10'h100, 0, 10'h000, 10'h057, 4'b1000)); // Start ignored in RUN
        vt.push_back(mk(C, 10'h000, 3, 10'h100, 10'h100, 4'b1000)); // push 058
        vt.push_back(mk(C, 10'h000, 3, 10'h200, 10'h200, 4'b1000)); // push 101
        vt.push_back(mk(C, 10'h000, 3, 10'h300, 10'h300, 4'b1000)); // push 201
        vt.push_back(mk(C, 10'h000, 3, 10'h040, 10'h040, 4'b1000)); // push 301, full
        vt.push_back(mk(C, 10'h000, 3, 10'h060, 10'h060, 4'b1010)); // dropped
        vt.push_back(mk(R, 10'h000, 0, 10'h000, 10'h301, 4'b1010));
        vt.push_back(mk(R, 10'h000, 0, 10'h000, 10'h201, 4'b1010));
        vt.push_back(mk(R, 10'h000, 0, 10'h000, 10'h101, 4'b1010));
        vt.push_back(mk(R, 10'h000, 0, 10'h000, 10'h058, 4'b1010));
        vt.push_back(mk(A, 10'h000, 0, 10'h030, 10'h030, 4'b1010));
        vt.push_back(mk(R, 10'h000, 0, 10'h000, 10'h031, 4'b1011)); // empty pop
        vt.push_back(mk(N, 10'h000, 0, 10'h000, 10'h032, 4'b1011));
        vt.push_back(mk(C, 10'h000, 1, 10'h111, 10'h111, 4'b1011)); // push 033
        vt.push_back(mk(ST|A|H|C, 10'h000, 2, 10'h222, 10'h111, 4'b1011));
        vt.push_back(mk(R, 10'h000, 0, 10'h000, 10'h033, 4'b1011)); // single entry left
        vt.push_back(mk(H, 10'h000, 0, 10'h000, 10'h033, 4'b0111)); // DONE
        vt.push_back(mk(S, 10'h2AA, 0, 10'h000, 10'h033, 4'b0011)); // ignored, now IDLE
        vt.push_back(mk(A|C|B, 10'h000, 1, 10'h155, 10'h033, 4'b0011));
        vt.push_back(mk(S, 10'h2AA, 0, 10'h000, 10'h2AA, 4'b1011));

        for (int unsigned i = 0; i < vt.size(); i++)
            step($sformatf("vec%0d", i), vt[i]);

        // Reset during a Call with a live stack entry; stack must come back empty.
        step("pre_rst_call", mk(C, 10'h000, 0, 10'h010, 10'h010, 4'b1011));
        rst = 1'b1;
        drive(C, 10'h000, 0, 10'h020);
        @(posedge clk); #1;
        check_out("rst_mid", 10'h000, 4'b0000);
        rst = 1'b0;
        step("idle_after_rst", mk(R, 10'h000, 0, 10'h000, 10'h000, 4'b0000));
        step("restart", mk(S, 10'h080, 0, 10'h000, 10'h080, 4'b1000));
        step("ret_empty", mk(R, 10'h000, 0, 10'h000, 10'h081, 4'b1001));
        step("seq_after", mk(N, 10'h000, 0, 10'h000, 10'h082, 4'b1001));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the fetch stage. It selects the next program counter from these sources: sequential PC+1, relative branch, absolute jump, call/return, stall, halt and start. It drives the branch-target lookup table's index port and consumes the LUT's target word in the same cycle. A small internal return-address stack supports call/return. All PC state lives here; the instruction ROM reads PC directly.

Parameters:
PC_W, 10, program counter width; matches the LUT target width
LUT_AW, 2, width of the target-LUT index
RAS_DEPTH, 4, return-address stack entries
RESET_PC, 0, PC value after reset

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  one-cycle pulse; begins execution at StartAddr (honoured in IDLE only)
StartAddr  in  PC_W  program entry point
Stall  in  1  hold PC this cycle
Halt  in  1  current instruction is halt
BranchRel  in  1  taken relative branch: PC + LutTarget
BranchAbs  in  1  absolute jump: PC = LutTarget
Call  in  1  absolute jump; push PC+1
Ret  in  1  pop return address into PC
LutSel  in  LUT_AW  target index from the instruction field
LutAddr  out  LUT_AW  index to the target LUT
LutTarget  in  PC_W  target word from the LUT (combinational)
PC  out  PC_W  current program counter
Running  out  1  high in RUN
Done  out  1  one-cycle pulse after halt
RasOverflow  out  1  sticky; push attempted while stack full
RasUnderflow  out  1  sticky; pop attempted while stack empty

Behaviour:
- Reset (synchronous, wins over everything): PC=RESET_PC, state=IDLE, Running=0, Done=0, stack empty, both sticky flags=0. Applies mid-run with any control input active.
- LutAddr = LutSel, combinational pass-through. The LUT target is used in the same cycle, so branch latency is zero bubbles: the taken target appears on PC at the next edge.
- States: IDLE, RUN, DONE.
- IDLE: PC holds. Start=1 -> PC<=StartAddr, go to RUN. All other controls are ignored.
- RUN: exactly one action per cycle. Priority, highest first:
  - Stall: PC holds; stack unchanged.
  - Halt: PC holds; go to DONE.
  - Ret:
    - stack non-empty: PC<=top, pop.
    - stack empty: PC<=PC+1, RasUnderflow<=1.
  - Call: PC<=LutTarget.
    - stack not full: push PC+1.
    - stack full: push dropped, RasOverflow<=1; the jump still occurs.
  - BranchAbs: PC<=LutTarget.
  - BranchRel: PC<=PC+LutTarget, modulo 2^PC_W. Two's-complement wrap, so 0x3F0 means -16.
  - none of the above: PC<=PC+1.
- Start in RUN or DONE is ignored.
- DONE: Done=1 for exactly this one cycle, Running=0, PC holds; unconditionally go to IDLE next cycle.
- PC+1 wraps from 2^PC_W-1 to 0. A pushed return address of PC+1 wraps the same way.
- Outputs are registered except LutAddr. Running=(state==RUN).
- Sticky flags clear only on Reset.

Decomposition:
- Package pc_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - next-PC source enum {HOLD, SEQ, REL, ABS, CALL, RET, START}
  - PC_W default constant
- The priority encoder lives in pc_sequencer and produces the source enum.
- One sub-module, pc_ras: a LIFO of RAS_DEPTH x PC_W.
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty.
  - Synchronous reset to empty.
  - Simultaneous push+pop never occurs, because the encoder guarantees exclusivity.

Test Plan:
1. Reset, then Start with StartAddr=0x010 -> PC=0x010 next cycle, Running=1. Three idle cycles -> PC=0x011, 0x012, 0x013.
2. PC=0x020, BranchRel, LutSel=0, LutTarget=0x3F0 -> LutAddr=0, PC=0x010. Separately, PC=0x3FF with no control -> PC=0x000.
3. Call at PC=0x050 with LutTarget=0x007 -> PC=0x007. Later Ret -> PC=0x051. Five nested Calls -> RasOverflow=1 on the fifth; the fifth jump is still taken; four Rets return to the first four addresses.
4. Ret with empty stack at PC=0x030 -> PC=0x031, RasUnderflow=1; the flag stays 1 through subsequent cycles until Reset.
5. Stall=1 together with BranchAbs, Halt and Call -> PC unchanged and stack unchanged. Then Halt alone -> Done=1 for one cycle with Running=0, then IDLE with PC held. A Start during that DONE cycle is ignored.
6. Reset asserted in RUN in the same cycle as Call with a non-empty stack -> PC=RESET_PC, state IDLE, stack empty, flags 0. A following Ret after a restart produces RasUnderflow=1.
